// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM state encoding, byte limit
// and a constant-width helper.
package spi_arb_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int MAX_NBYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_START = S_START,
        ST_WAIT  = S_WAIT,
        ST_DONE  = S_DONE,
        ST_GAP   = S_GAP
    } state_t;

    // Ceiling log2, never less than 1 so that counters keep at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping to index 0. Produces a one-hot grant and its encoded index.
module spi_rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int i = 0; i < N_REQ; i++) begin
            // Explicit wrap so non-power-of-two requester counts stay in range.
            cand = int'(ptr) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!any && req[PTR_W'(cand)]) begin
                any                 = 1'b1;
                gnt[PTR_W'(cand)]   = 1'b1;
                idx                 = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin sharing of one SPI master core between N_REQ requesters, with
// request validation and a slave-deselect guard gap. Optional WAIT watchdog
// is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int N_SLAVE        = 4,
    parameter int SS_W           = 2,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*32-1:0]    req_data_i,
    input  logic [N_REQ*3-1:0]     req_nbytes_i,
    input  logic [N_REQ*SS_W-1:0]  req_slave_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic                   err_o,
    output logic [31:0]            rdata_o,
    output logic                   spi_start_o,
    output logic [31:0]            spi_wdata_o,
    output logic [2:0]             spi_nbytes_o,
    output logic [N_SLAVE-1:0]     spi_ss_o,
    input  logic                   spi_done_i,
    input  logic [31:0]            spi_rdata_i,
`ifdef SPI_ARB_TIMEOUT_EN
    output logic                   timeout_o,
`endif
    output logic [2:0]             state_o
);

    // Handshake: a requester holds req_i until it sees done_o; gnt_o is high
    // from the latch edge through the DONE cycle; spi_start_o is a single
    // cycle pulse and spi_done_i is only honoured in WAIT.

    localparam int PTR_W = clog2(N_REQ);
    localparam int GAP_W = clog2(GAP_CYCLES + 1);

    state_t             state, state_nx;
    logic [PTR_W-1:0]   rr_ptr, idx_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic               err_q;
    logic               wait_expired;

    logic [N_REQ-1:0]   arb_gnt;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_any;
    logic [31:0]        pick_data;
    logic [2:0]         pick_nbytes;
    logic [SS_W-1:0]    pick_slave;
    logic               pick_bad;

    spi_rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
        .req (req_i),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        pick_data   = req_data_i[arb_idx*32 +: 32];
        pick_nbytes = req_nbytes_i[arb_idx*3 +: 3];
        pick_slave  = req_slave_i[arb_idx*SS_W +: SS_W];
        pick_bad    = (pick_nbytes == 3'd0) || (pick_nbytes > 3'(MAX_NBYTES)) ||
                      (32'(pick_slave) >= 32'(N_SLAVE));
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO_W = clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] wait_cnt;

    assign wait_expired = (state == ST_WAIT) && (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (state == ST_START) wait_cnt <= '0;
            else if (state == ST_WAIT) wait_cnt <= wait_cnt + TMO_W'(1);
            if (wait_expired && !spi_done_i) timeout_o <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign wait_expired = 1'b0;
    assign unused_tmo   = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (arb_any) state_nx = pick_bad ? ST_DONE : ST_START;
            ST_START: state_nx = ST_WAIT;
            ST_WAIT:  if (spi_done_i || wait_expired) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_GAP;
            ST_GAP:   if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_o        <= '0;
            idx_q        <= '0;
            rr_ptr       <= '0;
            err_q        <= 1'b0;
            rdata_o      <= '0;
            spi_wdata_o  <= '0;
            spi_nbytes_o <= '0;
            spi_ss_o     <= '1;
            gap_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_o        <= arb_gnt;
                        idx_q        <= arb_idx;
                        spi_wdata_o  <= pick_data;
                        spi_nbytes_o <= pick_nbytes;
                        // Rejected requests never touch the bus.
                        if (pick_bad) begin
                            err_q   <= 1'b1;
                            rdata_o <= '0;
                        end else begin
                            err_q    <= 1'b0;
                            spi_ss_o <= ~(N_SLAVE'(1) << pick_slave);
                        end
                    end
                end
                ST_WAIT: begin
                    if (spi_done_i) begin
                        rdata_o  <= spi_rdata_i;
                        spi_ss_o <= '1;
                    end else if (wait_expired) begin
                        rdata_o  <= '0;
                        err_q    <= 1'b1;
                        spi_ss_o <= '1;
                    end
                end
                ST_DONE: begin
                    gnt_o   <= '0;
                    gap_cnt <= '0;
                    rr_ptr  <= (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + PTR_W'(1);
                end
                ST_GAP: gap_cnt <= gap_cnt + GAP_W'(1);
                default: ;
            endcase
        end
    end

    assign spi_start_o = (state == ST_START);
    assign done_o      = (state == ST_DONE) ? gnt_o : '0;
    assign err_o       = (state == ST_DONE) && err_q;
    assign state_o     = state;

endmodule
